// File: rtl/dsp_dot_accum.sv
// rtl/dsp_dot_accum.sv - framed dot-product-and-accumulate engine
// Pipeline: input regs, per-lane product regs, registered adder tree, accumulator.
module dsp_dot_accum #(
    parameter int LANES     = 4,
    parameter int IDATAW    = 8,
    parameter int ODATAW    = 32,
    parameter int SIGNED    = 1,
    parameter int SATURATE  = 1,
    parameter int USE_CHAIN = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    input  logic                     i_first,
    input  logic                     i_last,
    input  logic [LANES*IDATAW-1:0]  i_x,
    input  logic [LANES*IDATAW-1:0]  i_y,
    input  logic [ODATAW-1:0]        i_chainin,
    output logic                     o_valid,
    output logic [ODATAW-1:0]        o_result,
    output logic                     o_overflow
);

    localparam int LG = $clog2(LANES);
    localparam int PW = 2 * IDATAW;
    localparam int TW = PW + LG;
    localparam int D  = LG + 2;
    localparam int NN = 2 * LANES - 1;

    logic [D-1:0]              v_q, f_q, l_q;
    logic [ODATAW-1:0]         ch_q [D];
    logic [LANES*IDATAW-1:0]   x_q, y_q;
    // Heap-ordered tree: leaves at LANES-1.., node i sums children 2i+1 and 2i+2.
    logic [TW-1:0]             t_q [NN];
    logic [PW-1:0]             prod [LANES];
    logic [TW-1:0]             prod_ext [LANES];

    logic [ODATAW-1:0]         acc_q, acc_d;
    logic                      flag_q, flag_d;
    logic                      o_valid_q, o_valid_d;
    logic [ODATAW-1:0]         o_result_q, o_result_d;
    logic                      o_overflow_q, o_overflow_d;

    logic [ODATAW-1:0]         sum_ext, add_a, add_res, sat_val;
    logic [ODATAW:0]           raw;
    logic                      ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            f_q <= '0;
            l_q <= '0;
        end else begin
            v_q <= {v_q[D-2:0], i_valid};
            f_q <= {f_q[D-2:0], i_first};
            l_q <= {l_q[D-2:0], i_last};
        end
    end

    always_ff @(posedge clk) begin
        x_q      <= i_x;
        y_q      <= i_y;
        ch_q[0]  <= i_chainin;
        for (int s = 1; s < D; s++) begin
            ch_q[s] <= ch_q[s-1];
        end
        for (int k = 0; k < LANES; k++) begin
            t_q[LANES-1+k] <= prod_ext[k];
        end
        for (int i = 0; i < LANES - 1; i++) begin
            t_q[i] <= t_q[2*i+1] + t_q[2*i+2];
        end
    end

    // Operands are widened first so the low PW bits of the product are exact.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            logic [PW-1:0] xe, ye;
            if (SIGNED != 0) begin
                xe = PW'($signed(x_q[k*IDATAW +: IDATAW]));
                ye = PW'($signed(y_q[k*IDATAW +: IDATAW]));
            end else begin
                xe = PW'(x_q[k*IDATAW +: IDATAW]);
                ye = PW'(y_q[k*IDATAW +: IDATAW]);
            end
            prod[k] = xe * ye;
            if (SIGNED != 0) begin
                prod_ext[k] = TW'($signed(prod[k]));
            end else begin
                prod_ext[k] = TW'(prod[k]);
            end
        end
    end

    always_comb begin
        if (SIGNED != 0) begin
            sum_ext = ODATAW'($signed(t_q[0]));
        end else begin
            sum_ext = ODATAW'(t_q[0]);
        end
        if (f_q[D-1]) begin
            add_a = (USE_CHAIN != 0) ? ch_q[D-1] : '0;
        end else begin
            add_a = acc_q;
        end
        raw = {1'b0, add_a} + {1'b0, sum_ext};
        if (SIGNED != 0) begin
            ovf     = (add_a[ODATAW-1] == sum_ext[ODATAW-1]) &&
                      (raw[ODATAW-1] != add_a[ODATAW-1]);
            sat_val = add_a[ODATAW-1] ? {1'b1, {(ODATAW-1){1'b0}}}
                                      : {1'b0, {(ODATAW-1){1'b1}}};
        end else begin
            ovf     = raw[ODATAW];
            sat_val = '1;
        end
        add_res = (ovf && (SATURATE != 0)) ? sat_val : raw[ODATAW-1:0];
    end

    // The group flag restarts on a first beat before this beat's own overflow is folded in.
    always_comb begin
        acc_d        = acc_q;
        flag_d       = flag_q;
        o_valid_d    = 1'b0;
        o_result_d   = o_result_q;
        o_overflow_d = o_overflow_q;
        if (v_q[D-1]) begin
            acc_d  = add_res;
            flag_d = ovf | (~f_q[D-1] & flag_q);
            if (l_q[D-1]) begin
                o_valid_d    = 1'b1;
                o_result_d   = add_res;
                o_overflow_d = flag_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q        <= '0;
            flag_q       <= 1'b0;
            o_valid_q    <= 1'b0;
            o_result_q   <= '0;
            o_overflow_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            flag_q       <= flag_d;
            o_valid_q    <= o_valid_d;
            o_result_q   <= o_result_d;
            o_overflow_q <= o_overflow_d;
        end
    end

    assign o_valid    = o_valid_q;
    assign o_result   = o_result_q;
    assign o_overflow = o_overflow_q;

endmodule
